// File: rtl/run_ctrl_pkg.sv
// Shared types, widths and helpers for the run controller.
package run_ctrl_pkg;

  localparam int CYC_W  = 16;
  localparam int MEM_AW = 8;
  localparam int MEM_DW = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CRST = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CRST = ST_CRST,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN,
    S_ERR  = ST_ERR
  } run_state_e;

  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + CYC_ONE;
  endfunction

endpackage

// File: rtl/run_cyc_ctr.sv
// Saturating run-cycle counter with synchronous clear and count enable.
module run_cyc_ctr
  import run_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CYC_W-1:0] o_count
);

  logic [CYC_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_ctrl.sv
// Host/core run sequencer: core reset pulse, run with cycle count, shared memory arbitration.
// Optional watchdog (ERR state, timeout flag) built when RUN_CTRL_WDOG_EN is defined.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          D       = 8,
  parameter logic [15:0] MAX_CYC = 16'd4000,
  parameter int          RST_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycles,
  output logic              core_rst,
  input  logic              core_done,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdat,
  output logic              host_gnt,
  output logic [MEM_DW-1:0] host_rdat,
  input  logic              core_we,
  input  logic [MEM_AW-1:0] core_addr,
  input  logic [MEM_DW-1:0] core_wdat,
  output logic [MEM_DW-1:0] core_rdat,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdat,
  input  logic [MEM_DW-1:0] mem_rdat,
  output logic [2:0]        dbg_state
);

  if (D < 1 || MAX_CYC == 16'd0 || RST_CYC < 1 || RST_CYC > 15) begin : g_bad_param
    $error("run_ctrl: parameter out of range");
  end

  localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [3:0] r_rst_cnt;
  logic       r_ack;
  logic       r_busy;
  logic       r_gnt;
  logic       r_core_rst;
  logic       w_start;
  logic       w_next_busy;

  assign w_start = (r_state == ST_IDLE) && req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = ST_CRST;
      ST_CRST: if (r_rst_cnt == 4'd0) w_next = ST_RUN;
      ST_RUN: begin
        // core_done has priority over the watchdog when both land on the same cycle
        if (core_done) begin
          w_next = ST_FIN;
        end
`ifdef RUN_CTRL_WDOG_EN
        else if (cycles == MAX_CYC - 16'd1) begin
          w_next = ST_ERR;
        end
`endif
      end
      ST_FIN, ST_ERR: if (!req) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_next_busy = (w_next == ST_CRST) || (w_next == ST_RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rst_cnt  <= RST_LAST;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_gnt      <= 1'b1;
      r_core_rst <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_ack      <= (w_next == ST_FIN) || (w_next == ST_ERR);
      r_busy     <= w_next_busy;
      r_gnt      <= !w_next_busy;
      r_core_rst <= (w_next != ST_RUN);
      if (r_state == ST_IDLE) begin
        r_rst_cnt <= RST_LAST;
      end else if (r_state == ST_CRST && r_rst_cnt != 4'd0) begin
        r_rst_cnt <= r_rst_cnt - 4'd1;
      end
    end
  end

  run_cyc_ctr u_cyc (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_start),
    .i_en    (r_state == ST_RUN),
    .o_count (cycles)
  );

`ifdef RUN_CTRL_WDOG_EN
  logic r_timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_timeout <= 1'b0;
    end else if (r_state == ST_RUN && w_next == ST_ERR) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign host_gnt  = r_gnt;
  assign core_rst  = r_core_rst;
  assign dbg_state = r_state;

  // Only the granted side reaches the memory, so a host write while busy is dropped.
  assign mem_we    = r_gnt ? host_we   : core_we;
  assign mem_addr  = r_gnt ? host_addr : core_addr;
  assign mem_wdat  = r_gnt ? host_wdat : core_wdat;
  assign host_rdat = mem_rdat;
  assign core_rdat = mem_rdat;

endmodule
